window_stats_buffer: RTL
========================

// Module: window_stats_buffer
// PURPOSE
//  Parametrised sliding-window sample store for the temperature monitor path.
//  Accepts unsigned samples over a valid/ready handshake into a DEPTH-entry circular buffer.
//  Reports windowed max/min, recomputed by a scan FSM after each write.
//  Reports an exact windowed average: the running sum drops each evicted sample.
//  Sits between the sensor sampler and the display/alarm logic.
// PARAMETERS
//  WIDTH  8   sample width in bits (unsigned)
//  DEPTH  8   window length; power of two, >= 2
//  AW     $clog2(DEPTH)  derived; not overridden
// PORTS
//  clk        in   1           single clock, rising edge
//  reset      in   1           asynchronous, active-high; clears all state
//  clear      in   1           synchronous flush of window and statistics
//  in_valid   in   1           sample offered
//  in_ready   out  1           block can accept a sample
//  in_data    in   WIDTH       sample value
//  rd_idx     in   AW          read index; 0 = newest sample, 1 = previous, ...
//  rd_data    out  WIDTH       combinational read of entry rd_idx; 0 if rd_idx >= count
//  count      out  AW+1        entries held, 0..DEPTH
//  full       out  1           count == DEPTH
//  stat_max   out  WIDTH       max over held entries
//  stat_min   out  WIDTH       min over held entries
//  stat_avg   out  WIDTH       sum >> AW; meaningful only when avg_valid
//  avg_valid  out  1           equals full
//  stats_done out  1           one-cycle pulse when stat_max/stat_min update
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0. State IDLE, wr_ptr = 0, sum = 0.
//  in_ready = (state == IDLE) && !clear.
//  Handshake: sample accepted on an edge where in_valid && in_ready; in_data is sampled there.
//  On accept:
//   - mem[wr_ptr] <= in_data; wr_ptr increments and wraps DEPTH-1 -> 0.
//   - count saturates at DEPTH.
//   - If already full: sum <= sum - mem[wr_ptr] + in_data; else sum <= sum + in_data.
//   - The evicted value is the pre-write content.
//  Sum register width: WIDTH+AW bits; no overflow possible.
//  stat_avg = sum[WIDTH+AW-1:AW] (truncating) and is visible the cycle after accept.
//  FSM IDLE -> SCAN on accept.
//  SCAN:
//   - Walks scan index 0..count-1, newest first, one entry per cycle.
//   - Accumulators start at the newest sample.
//   - On the edge that consumes the last entry: stat_max/stat_min load, stats_done = 1
//     for the following cycle, state -> IDLE.
//  Latency: stat_max/stat_min are valid count cycles after the accept edge
//   (count after increment). Samples arrive at most once per count+1 cycles.
//  Old stat_max/stat_min are held stable during SCAN.
//  clear: highest priority after reset.
//   - In any state it returns to IDLE, sets count, sum, wr_ptr, stat_* to 0,
//     and drops the in-flight sample and scan.
//   - stats_done is not pulsed.
//  Wrap-around: after DEPTH+k accepts, the window is the last DEPTH samples.
//   rd_idx = DEPTH-1 is the oldest sample.
//  Reset mid-SCAN: immediate IDLE, everything zeroed, no stats_done pulse.
//  in_valid while !in_ready: ignored; the source must hold the sample.
// STRUCTURE
//  temp_mon_pkg: stats_state_e {IDLE, SCAN}.
//  Sub-module ring_store (WIDTH, DEPTH):
//   - Storage, wr_ptr, count.
//   - Two combinational read ports addressed newest-relative: rd_idx and scan index.
//   - Returns the evicted value.
//  Top level holds the FSM, sum, accumulators and outputs.
// TESTING
//  1 reset mid-stream, then 3 accepts 10,30,20 -> count=3; after 3 cycles stats_done;
//    max=30, min=10; avg_valid=0; rd_idx0=20, rd_idx2=10.
//  2 DEPTH=8, accept 1..8 -> full=1, avg_valid=1, sum=36, stat_avg=4; max=8, min=1.
//  3 then accept 100 -> sample 1 evicted; sum=135, stat_avg=16, min=2, max=100;
//    rd_idx7=2, rd_idx0=100.
//  4 in_valid held through SCAN with changing data -> only the value present when
//    in_ready=1 is stored; count increments once.
//  5 clear asserted mid-SCAN with in_valid=1 -> next cycle count=0, stats=0,
//    no stats_done, sample not stored.
//  6 async reset asserted between edges during SCAN -> outputs 0 immediately;
//    first accept after release behaves as scenario 1.

Source files
------------

// File: rtl/temp_mon_pkg.sv
// Shared types for the temperature-monitor window statistics path.
package temp_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } stats_state_e;

endpackage

// File: rtl/ring_store.sv
// Circular sample store with newest-relative read ports and eviction output.
module ring_store #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_idx_i,
  input  logic [AW-1:0]    scan_idx_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] scan_data_o,
  output logic [WIDTH-1:0] evict_data_o,
  output logic [AW:0]      count_o,
  output logic             full_o
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW:0]      count_q;
  logic [AW-1:0]    rdAddr;
  logic [AW-1:0]    scanAddr;

  // Pointer wraps for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wrPtr_q] <= wr_data_i;
      wrPtr_q        <= wrPtr_q + 1'b1;
      if (count_q != FullCount) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Index 0 is the slot just behind the write pointer, i.e. the newest sample.
  assign rdAddr       = wrPtr_q - AW'(1) - rd_idx_i;
  assign scanAddr     = wrPtr_q - AW'(1) - scan_idx_i;
  assign rd_data_o    = ({1'b0, rd_idx_i} < count_q) ? mem_q[rdAddr] : '0;
  assign scan_data_o  = mem_q[scanAddr];
  assign evict_data_o = mem_q[wrPtr_q];
  assign count_o      = count_q;
  assign full_o       = (count_q == FullCount);

endmodule

// File: rtl/window_stats_buffer.sv
// Sliding-window sample buffer reporting windowed max/min (by scan) and average.
module window_stats_buffer
  import temp_mon_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic [WIDTH-1:0] stat_max,
  output logic [WIDTH-1:0] stat_min,
  output logic [WIDTH-1:0] stat_avg,
  output logic             avg_valid,
  output logic             stats_done
);

  localparam int SW = WIDTH + AW;

  stats_state_e     state_q, state_d;
  logic [AW-1:0]    scanIdx_q, scanIdx_d;
  logic [WIDTH-1:0] accMax_q, accMax_d;
  logic [WIDTH-1:0] accMin_q, accMin_d;
  logic [WIDTH-1:0] statMax_q, statMax_d;
  logic [WIDTH-1:0] statMin_q, statMin_d;
  logic             statsDone_q, statsDone_d;
  logic [SW-1:0]    sum_q, sum_d;

  logic             accept;
  logic             lastEntry;
  logic [WIDTH-1:0] scanData;
  logic [WIDTH-1:0] evictData;
  logic [WIDTH-1:0] curMax;
  logic [WIDTH-1:0] curMin;

  assign in_ready = (state_q == IDLE) && !clear;
  assign accept   = in_valid && in_ready;

  ring_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear),
    .wr_en_i      (accept),
    .wr_data_i    (in_data),
    .rd_idx_i     (rd_idx),
    .scan_idx_i   (scanIdx_q),
    .rd_data_o    (rd_data),
    .scan_data_o  (scanData),
    .evict_data_o (evictData),
    .count_o      (count),
    .full_o       (full)
  );

  // The first scanned entry seeds the accumulators instead of comparing against stale values.
  assign curMax    = (scanIdx_q == '0 || scanData > accMax_q) ? scanData : accMax_q;
  assign curMin    = (scanIdx_q == '0 || scanData < accMin_q) ? scanData : accMin_q;
  assign lastEntry = (({1'b0, scanIdx_q} + 1'b1) == count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      scanIdx_q   <= '0;
      accMax_q    <= '0;
      accMin_q    <= '0;
      statMax_q   <= '0;
      statMin_q   <= '0;
      statsDone_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      scanIdx_q   <= scanIdx_d;
      accMax_q    <= accMax_d;
      accMin_q    <= accMin_d;
      statMax_q   <= statMax_d;
      statMin_q   <= statMin_d;
      statsDone_q <= statsDone_d;
      sum_q       <= sum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scanIdx_d   = scanIdx_q;
    accMax_d    = accMax_q;
    accMin_d    = accMin_q;
    statMax_d   = statMax_q;
    statMin_d   = statMin_q;
    statsDone_d = 1'b0;
    sum_d       = sum_q;

    if (clear) begin
      state_d   = IDLE;
      scanIdx_d = '0;
      accMax_d  = '0;
      accMin_d  = '0;
      statMax_d = '0;
      statMin_d = '0;
      sum_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // Evicted value is the pre-write slot content, so the sum stays exact.
            if (full) begin
              sum_d = sum_q - SW'(evictData) + SW'(in_data);
            end else begin
              sum_d = sum_q + SW'(in_data);
            end
            scanIdx_d = '0;
            state_d   = SCAN;
          end
        end
        SCAN: begin
          accMax_d = curMax;
          accMin_d = curMin;
          if (lastEntry) begin
            statMax_d   = curMax;
            statMin_d   = curMin;
            statsDone_d = 1'b1;
            state_d     = IDLE;
          end else begin
            scanIdx_d = scanIdx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stat_max   = statMax_q;
  assign stat_min   = statMin_q;
  assign stat_avg   = sum_q[SW-1:AW];
  assign avg_valid  = full;
  assign stats_done = statsDone_q;

endmodule
